// File: rtl/ar_rxd_pkg.sv
// Shared ARINC 429 receive definitions: word geometry, line-rate table,
// bit-period helper, FSM encoding and word-level helpers.
package arinc429_pkg;

  localparam int WORD_BITS  = 32;
  localparam int LABEL_BITS = 8;
  localparam int DATA_BITS  = 23;

  // Line rate in bit/s for each Nvel code.
  localparam int unsigned RATE_NVEL0 = 32'd12_500;
  localparam int unsigned RATE_NVEL1 = 32'd50_000;
  localparam int unsigned RATE_NVEL2 = 32'd100_000;
  localparam int unsigned RATE_NVEL3 = 32'd250_000;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_PULSE   = 2'd1,
    RX_WAITLOW = 2'd2
  } rx_state_e;

  function automatic int unsigned rate_bps(input logic [1:0] nvel);
    int unsigned r;
    case (nvel)
      2'd0:    r = RATE_NVEL0;
      2'd1:    r = RATE_NVEL1;
      2'd2:    r = RATE_NVEL2;
      2'd3:    r = RATE_NVEL3;
      default: r = RATE_NVEL3;
    endcase
    return r;
  endfunction

  function automatic int unsigned tbit_clocks(input int unsigned fclk, input logic [1:0] nvel);
    return fclk / rate_bps(nvel);
  endfunction

  // A valid word carries an odd number of ones across all 32 bits.
  function automatic logic word_parity_ok(input logic [WORD_BITS-1:0] w);
    return ^w;
  endfunction

  // Label arrives MSB first, so arrival order is bit-reversed.
  function automatic logic [LABEL_BITS-1:0] label_of(input logic [WORD_BITS-1:0] w);
    logic [LABEL_BITS-1:0] l;
    for (int k = 0; k < LABEL_BITS; k++) begin
      l[LABEL_BITS-1-k] = w[k];
    end
    return l;
  endfunction

endpackage

// File: rtl/ar_rxd_if.sv
// Line-pair input and decoded-word output bundle of the ARINC 429 receiver.
interface ar_rxd_if;
  import arinc429_pkg::*;

  logic [1:0]            Nvel;
  logic                  RXD0;
  logic                  RXD1;
  logic [LABEL_BITS-1:0] ADR;
  logic [DATA_BITS-1:0]  DAT;
  logic                  rdy;
  logic                  par_ok;
  logic                  err_frm;
  logic                  err_line;
  logic                  en_rx;

  modport master (
    output Nvel, RXD0, RXD1,
    input  ADR, DAT, rdy, par_ok, err_frm, err_line, en_rx
  );

  modport slave (
    input  Nvel, RXD0, RXD1,
    output ADR, DAT, rdy, par_ok, err_frm, err_line, en_rx
  );
endinterface

// File: rtl/ar_rx_line_sync.sv
// Two-flop synchroniser for the RXD0/RXD1 pair with rising-edge detect
// on the synchronised levels.
module ar_rx_line_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rxd,
  output logic [1:0] lvl,
  output logic [1:0] rise
);

  logic [1:0] meta_r;
  logic [1:0] sync_r;
  logic [1:0] prev_r;

  // Synchroniser chain plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
      prev_r <= 2'b00;
    end else begin
      meta_r <= rxd;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign lvl  = sync_r;
  assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/ar_rxd.sv
// ARINC 429 bipolar RZ receiver: qualifies line pulses by width, assembles
// 32-bit words, checks odd parity and reports timeout and line faults.
module ar_rxd
  import arinc429_pkg::*;
#(
  parameter int unsigned Fclk     = 50_000_000,
  parameter int unsigned MINW_DIV = 8,
  parameter int unsigned TO_BITS  = 2
) (
  input  logic    clk,
  input  logic    rst,
  ar_rxd_if.slave bus
);

  localparam int unsigned TMO_MAX = TO_BITS * tbit_clocks(Fclk, 2'd0);
  localparam int          CNT_W   = $clog2(TMO_MAX + 1);

  localparam logic [CNT_W-1:0] MINW0 = CNT_W'(tbit_clocks(Fclk, 2'd0) / MINW_DIV);
  localparam logic [CNT_W-1:0] MINW1 = CNT_W'(tbit_clocks(Fclk, 2'd1) / MINW_DIV);
  localparam logic [CNT_W-1:0] MINW2 = CNT_W'(tbit_clocks(Fclk, 2'd2) / MINW_DIV);
  localparam logic [CNT_W-1:0] MINW3 = CNT_W'(tbit_clocks(Fclk, 2'd3) / MINW_DIV);
  localparam logic [CNT_W-1:0] TMO0  = CNT_W'(TO_BITS * tbit_clocks(Fclk, 2'd0));
  localparam logic [CNT_W-1:0] TMO1  = CNT_W'(TO_BITS * tbit_clocks(Fclk, 2'd1));
  localparam logic [CNT_W-1:0] TMO2  = CNT_W'(TO_BITS * tbit_clocks(Fclk, 2'd2));
  localparam logic [CNT_W-1:0] TMO3  = CNT_W'(TO_BITS * tbit_clocks(Fclk, 2'd3));

  logic [1:0]            lvl_s;
  logic [1:0]            rise_s;
  logic                  both_s;
  logic                  both_r;
  logic                  line_err_s;
  rx_state_e             state_r;
  rx_state_e             state_nx_s;
  logic                  accept_s;
  logic                  start_s;
  logic                  tmo_hit_s;
  logic                  line_r;
  logic [1:0]            nvel_r;
  logic [1:0]            rate_sel_s;
  logic [CNT_W-1:0]      minw_s;
  logic [CNT_W-1:0]      tmo_s;
  logic [CNT_W-1:0]      width_r;
  logic [CNT_W-1:0]      gap_r;
  logic [4:0]            bitcnt_r;
  logic [WORD_BITS-2:0]  word_r;
  logic [WORD_BITS-1:0]  full_s;
  logic [LABEL_BITS-1:0] adr_r;
  logic [DATA_BITS-1:0]  dat_r;
  logic                  par_ok_r;
  logic                  rdy_r;
  logic                  err_frm_r;
  logic                  err_line_r;
  logic                  en_rx_r;

  ar_rx_line_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rxd  ({bus.RXD1, bus.RXD0}),
    .lvl  (lvl_s),
    .rise (rise_s)
  );

  assign both_s     = &lvl_s;
  assign line_err_s = both_s & ~both_r;
  assign tmo_hit_s  = (bitcnt_r != 5'd0) && (gap_r >= tmo_s);
  assign full_s     = {line_r, word_r};

  // Rate lookup; the first pulse of a word is qualified against the live Nvel.
  always_comb begin
    rate_sel_s = nvel_r;
    if (bitcnt_r == 5'd0) begin
      rate_sel_s = bus.Nvel;
    end else begin
      rate_sel_s = nvel_r;
    end
    case (rate_sel_s)
      2'd0:    minw_s = MINW0;
      2'd1:    minw_s = MINW1;
      2'd2:    minw_s = MINW2;
      2'd3:    minw_s = MINW3;
      default: minw_s = MINW3;
    endcase
    case (nvel_r)
      2'd0:    tmo_s = TMO0;
      2'd1:    tmo_s = TMO1;
      2'd2:    tmo_s = TMO2;
      2'd3:    tmo_s = TMO3;
      default: tmo_s = TMO3;
    endcase
  end

  // Pulse FSM next-state; both lines high overrides every state.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    start_s    = 1'b0;
    if (both_s) begin
      state_nx_s = RX_WAITLOW;
    end else begin
      case (state_r)
        RX_IDLE: begin
          if (rise_s != 2'b00) begin
            state_nx_s = RX_PULSE;
            start_s    = 1'b1;
          end else begin
            state_nx_s = RX_IDLE;
          end
        end
        RX_PULSE: begin
          if (!lvl_s[line_r]) begin
            state_nx_s = RX_IDLE;
          end else if ((width_r + CNT_W'(1)) >= minw_s) begin
            accept_s   = 1'b1;
            state_nx_s = RX_WAITLOW;
          end else begin
            state_nx_s = RX_PULSE;
          end
        end
        RX_WAITLOW: begin
          if (lvl_s == 2'b00) begin
            state_nx_s = RX_IDLE;
          end else begin
            state_nx_s = RX_WAITLOW;
          end
        end
        default: state_nx_s = RX_IDLE;
      endcase
    end
  end

  // FSM state, pulse-width counter, tracked line and line-fault history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RX_IDLE;
      width_r <= '0;
      line_r  <= 1'b0;
      both_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      both_r  <= both_s;
      if (state_r == RX_PULSE && state_nx_s == RX_PULSE) begin
        width_r <= width_r + CNT_W'(1);
      end else begin
        width_r <= '0;
      end
      if (start_s) begin
        line_r <= rise_s[1];
      end
    end
  end

  // Inter-pulse gap counter, only running inside a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_r <= '0;
    end else if (accept_s || tmo_hit_s || line_err_s || bitcnt_r == 5'd0) begin
      gap_r <= '0;
    end else begin
      gap_r <= gap_r + CNT_W'(1);
    end
  end

  // Word assembly, completion and fault pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_r   <= 5'd0;
      word_r     <= '0;
      nvel_r     <= 2'd0;
      adr_r      <= '0;
      dat_r      <= '0;
      par_ok_r   <= 1'b0;
      rdy_r      <= 1'b0;
      err_frm_r  <= 1'b0;
      err_line_r <= 1'b0;
      en_rx_r    <= 1'b0;
    end else begin
      rdy_r      <= 1'b0;
      err_frm_r  <= 1'b0;
      err_line_r <= line_err_s;
      if (line_err_s) begin
        bitcnt_r <= 5'd0;
        en_rx_r  <= 1'b0;
      end else if (accept_s) begin
        if (bitcnt_r == 5'd31) begin
          adr_r    <= label_of(full_s);
          dat_r    <= full_s[WORD_BITS-2:LABEL_BITS];
          par_ok_r <= word_parity_ok(full_s);
          rdy_r    <= 1'b1;
          bitcnt_r <= 5'd0;
          en_rx_r  <= 1'b0;
        end else begin
          word_r   <= {line_r, word_r[WORD_BITS-2:1]};
          bitcnt_r <= bitcnt_r + 5'd1;
          en_rx_r  <= 1'b1;
          if (bitcnt_r == 5'd0) begin
            nvel_r <= bus.Nvel;
          end
        end
      end else if (tmo_hit_s) begin
        err_frm_r <= 1'b1;
        bitcnt_r  <= 5'd0;
        en_rx_r   <= 1'b0;
      end
    end
  end

  assign bus.ADR      = adr_r;
  assign bus.DAT      = dat_r;
  assign bus.par_ok   = par_ok_r;
  assign bus.rdy      = rdy_r;
  assign bus.err_frm  = err_frm_r;
  assign bus.err_line = err_line_r;
  assign bus.en_rx    = en_rx_r;

endmodule

// File: tb/tb_ar_rxd.sv
// Directed plus randomized bench for ar_rxd: a behavioural line transmitter
// drives RXD0/RXD1 and received words are checked against the sent fields.
module tb_ar_rxd;

  localparam int unsigned FCLK = 5_000_000;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  ar_rxd_if bus ();

  ar_rxd #(.Fclk(FCLK), .MINW_DIV(8), .TO_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int rdy_cnt     = 0;
  int frm_cnt     = 0;
  int line_cnt    = 0;
  int en_bad      = 0;
  int glitch_at   = -1;
  int tx_nv       = 2;
  logic [31:0] cap_q[$];

  // Record every completed word and every fault pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rdy) begin
        rdy_cnt <= rdy_cnt + 1;
        cap_q.push_back({bus.par_ok, bus.ADR, bus.DAT});
      end
      if (bus.err_frm)  frm_cnt  <= frm_cnt + 1;
      if (bus.err_line) line_cnt <= line_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  function automatic int tbit_of(input int nv);
    int r;
    case (nv)
      0:       r = FCLK / 12500;
      1:       r = FCLK / 50000;
      2:       r = FCLK / 100000;
      default: r = FCLK / 250000;
    endcase
    return r;
  endfunction

  // Transmission order: label MSB first, data LSB first, then odd-parity bit.
  function automatic logic [31:0] frame(input logic [7:0] adr, input logic [22:0] dat,
                                        input logic flip);
    logic [31:0] f;
    for (int i = 0; i < 8; i++) f[i] = adr[7-i];
    for (int j = 0; j < 23; j++) f[8+j] = dat[j];
    f[31] = ((($countones(adr) + $countones(dat)) % 2) == 0) ^ flip;
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int idx);
    int half;
    half = tbit_of(tx_nv) / 2;
    if (b) bus.RXD1 = 1'b1;
    else   bus.RXD0 = 1'b1;
    repeat (half) @(posedge clk);
    bus.RXD0 = 1'b0;
    bus.RXD1 = 1'b0;
    if (idx == glitch_at) begin
      repeat (half / 2) @(posedge clk);
      bus.RXD1 = 1'b1;
      repeat (3) @(posedge clk);
      bus.RXD1 = 1'b0;
      repeat (half - half / 2 - 3) @(posedge clk);
    end else begin
      repeat (half) @(posedge clk);
    end
    #1;
    if (idx <= 30 && bus.en_rx !== 1'b1) en_bad++;
  endtask

  task automatic send_frame(input logic [31:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(f[i], i);
  endtask

  task automatic gap_bits(input int n);
    repeat (n * tbit_of(tx_nv)) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] adr, input logic [22:0] dat, input logic flip);
    send_frame(frame(adr, dat, flip), 32);
    gap_bits(4);
  endtask

  task automatic expect_word(input string tag, input logic [7:0] adr, input logic [22:0] dat,
                             input logic flip);
    logic [31:0] f;
    logic        exp_par;
    logic [31:0] got;
    f       = frame(adr, dat, flip);
    exp_par = ($countones(f) % 2) == 1;
    check({tag, "_avail"}, 64'(cap_q.size() > 0), 64'd1);
    if (cap_q.size() > 0) begin
      got = cap_q.pop_front();
      check({tag, "_adr"}, 64'(got[30:23]), 64'(adr));
      check({tag, "_dat"}, 64'(got[22:0]), 64'(dat));
      check({tag, "_par"}, 64'(got[31]), 64'(exp_par));
    end
  endtask

  initial begin
    logic [7:0]  a;
    logic [22:0] d;
    logic        fl;
    int r0, fc, lc, n;
    int rates[3];
    rates = '{0, 1, 3};

    bus.Nvel = 2'd2;
    bus.RXD0 = 1'b0;
    bus.RXD1 = 1'b0;
    rst      = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_outs", 64'({bus.ADR, bus.DAT, bus.rdy, bus.par_ok, bus.err_frm,
                             bus.err_line, bus.en_rx}), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);

    // Normal word at 100 kbit/s.
    r0 = rdy_cnt;
    en_bad = 0;
    send_word(8'h8D, 23'h702D00, 1'b0);
    expect_word("normal", 8'h8D, 23'h702D00, 1'b0);
    check("normal_rdy_once", 64'(rdy_cnt - r0), 64'd1);
    check("normal_en_rx_word", 64'(en_bad), 64'd0);
    check("normal_en_rx_after", 64'(bus.en_rx), 64'd0);

    // Same word with the parity bit inverted.
    send_word(8'h8D, 23'h702D00, 1'b1);
    expect_word("parity", 8'h8D, 23'h702D00, 1'b1);

    // Short RXD1 glitch between bits 5 and 6.
    a = 8'($urandom);
    d = 23'($urandom);
    glitch_at = 4;
    send_word(a, d, 1'b0);
    glitch_at = -1;
    expect_word("glitch", a, d, 1'b0);

    // Line stops after 10 bits.
    r0 = rdy_cnt;
    fc = frm_cnt;
    send_frame(frame(8'($urandom), 23'($urandom), 1'b0), 10);
    n = 0;
    while (frm_cnt == fc && n < 4 * tbit_of(tx_nv)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_frm", 64'(frm_cnt - fc), 64'd1);
    check("timeout_latency", 64'(n >= tbit_of(tx_nv) / 2 && n <= 2 * tbit_of(tx_nv)), 64'd1);
    check("timeout_hold", 64'({bus.ADR, bus.DAT}), 64'({a, d}));
    check("timeout_no_rdy", 64'(rdy_cnt - r0), 64'd0);
    check("timeout_en_rx", 64'(bus.en_rx), 64'd0);
    gap_bits(2);

    // Both lines high mid-word.
    r0 = rdy_cnt;
    fc = frm_cnt;
    lc = line_cnt;
    send_frame(frame(8'($urandom), 23'($urandom), 1'b0), 12);
    bus.RXD0 = 1'b1;
    bus.RXD1 = 1'b1;
    repeat (100) @(posedge clk);
    bus.RXD0 = 1'b0;
    bus.RXD1 = 1'b0;
    gap_bits(4);
    check("line_err_once", 64'(line_cnt - lc), 64'd1);
    check("line_no_frm", 64'(frm_cnt - fc), 64'd0);
    check("line_no_rdy", 64'(rdy_cnt - r0), 64'd0);
    a = 8'($urandom);
    d = 23'($urandom);
    send_word(a, d, 1'b0);
    expect_word("line_next", a, d, 1'b0);

    // Random words with random parity at 250 kbit/s.
    tx_nv    = 3;
    bus.Nvel = 2'd3;
    for (int k = 0; k < 4; k++) begin
      a  = 8'($urandom);
      d  = 23'($urandom);
      fl = 1'($urandom_range(1, 0));
      send_word(a, d, fl);
      expect_word("rand", a, d, fl);
    end

    // Nvel change mid-word must not affect the current word.
    a = 8'($urandom);
    d = 23'($urandom);
    send_frame(frame(a, d, 1'b0), 5);
    bus.Nvel = 2'd0;
    for (int i = 5; i < 32; i++) send_bit(frame(a, d, 1'b0) >> i, i);
    gap_bits(4);
    expect_word("nvel_latch", a, d, 1'b0);

    // Back-to-back words at the remaining rates.
    foreach (rates[i]) begin
      tx_nv    = rates[i];
      bus.Nvel = 2'(rates[i]);
      r0 = rdy_cnt;
      a  = 8'($urandom);
      d  = 23'($urandom);
      send_word(a, d, 1'b0);
      send_word(8'h01, 23'h7FFFFF, 1'b0);
      check("b2b_rdy_count", 64'(rdy_cnt - r0), 64'd2);
      expect_word("b2b_first", a, d, 1'b0);
      expect_word("b2b_second", 8'h01, 23'h7FFFFF, 1'b0);
    end

    // Reset at bit 20, then a clean word.
    tx_nv    = 2;
    bus.Nvel = 2'd2;
    send_frame(frame(8'($urandom), 23'($urandom), 1'b0), 20);
    rst = 1'b1;
    #1;
    check("reset_mid", 64'({bus.ADR, bus.DAT, bus.rdy, bus.par_ok, bus.err_frm,
                            bus.err_line, bus.en_rx}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    gap_bits(2);
    a = 8'($urandom);
    d = 23'($urandom);
    send_word(a, d, 1'b0);
    expect_word("after_reset", a, d, 1'b0);

    check("no_spurious_words", 64'(cap_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ar_rxd.md
Name: ar_rxd

Overview:
- ARINC 429 bipolar return-to-zero receiver.
- Sits directly downstream of the AR_TXD transmitter and consumes its TXD0/TXD1 line pair.
- Recovers each 32-bit word into label (ADR) and data (DAT) fields, checks odd parity, and flags framing and line faults.
- Self-clocked from line pulses; no recovered-clock PLL.

Parameters:
- Fclk, 50_000_000, system clock frequency in Hz; sets bit-period counts.
- MINW_DIV, 8, minimum valid pulse width = Tbit/MINW_DIV clocks.
- TO_BITS, 2, inter-pulse timeout in bit periods; aborts a partial word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- Nvel  in  2  rate select: 0=12.5k, 1=50k, 2=100k, 3=250k bit/s
- RXD0  in  1  line "0" (driven by TXD0), asynchronous
- RXD1  in  1  line "1" (driven by TXD1), asynchronous
- ADR  out  8  received label
- DAT  out  23  received data field (SDI+data+SSM)
- rdy  out  1  one-clock pulse: new word valid on ADR/DAT/par_ok
- par_ok  out  1  odd parity of the last word was correct
- err_frm  out  1  one-clock pulse: partial word aborted (timeout)
- err_line  out  1  one-clock pulse: RXD0 and RXD1 both high
- en_rx  out  1  high while a word is being received

Behaviour:
- Reset (async, rst=1): ADR=0, DAT=0, rdy=0, par_ok=0, err_frm=0, err_line=0, en_rx=0, bit count=0, state IDLE. Releasing rst mid-word discards the word.
- Input sync: RXD0/RXD1 pass through 2-FF synchronisers; all timing below counts from the synchronised signals.
- Tbit in clocks = Fclk/rate: 4000, 1000, 500, 200 at 50 MHz.
- Nvel is latched at the first qualified pulse of a word. A change in Nvel mid-word takes effect on the next word.
- States:
  - IDLE: both lines low. Either line goes high -> PULSE, width counter cleared.
  - PULSE: count clocks while the same line stays high.
    - Width reaches Tbit/MINW_DIV -> bit accepted (1 if RXD1, 0 if RXD0), move to WAITLOW.
    - Line drops before that -> glitch; ignore, return to IDLE, bit count unchanged.
  - WAITLOW: stay until both lines are low, then go to IDLE.
- Bit order:
  - Bits 1-8 go to ADR, MSB first (first bit -> ADR[7]).
  - Bits 9-31 go to DAT, LSB first (bit 9 -> DAT[0]).
  - Bit 32 is the parity bit.
- Parity: the 32 received bits must contain an odd number of ones for par_ok=1.
- Word completion:
  - On the clock after bit 32 is accepted: ADR, DAT and par_ok update together, rdy=1 for exactly one clock, en_rx returns to 0, bit count returns to 0.
  - ADR, DAT and par_ok hold until the next completed word.
- en_rx rises on acceptance of bit 1.
- Timeout: a gap counter resets on each accepted bit. If it reaches TO_BITS*Tbit while bit count is 1..31:
  - err_frm pulses for 1 clock;
  - bit count returns to 0;
  - en_rx returns to 0;
  - ADR/DAT are unchanged.
- Line error: if both synchronised lines are high in any state:
  - err_line pulses once per occurrence (edge of the condition);
  - the partial word is discarded;
  - the FSM waits in WAITLOW until both lines are low.
  - err_frm is not also raised for that word.
- Words arriving back-to-back with the standard 4-bit gap must all be received; there is no dead time after rdy.

Decomposition:
- Package arinc429_pkg holds:
  - WORD_BITS=32, LABEL_BITS=8, DATA_BITS=23;
  - rate table (bit/s per Nvel code);
  - function tbit_clocks(Fclk, Nvel);
  - FSM state encoding.
- Sub-module ar_rx_line_sync: 2-FF synchroniser for RXD0/RXD1 plus rising-edge detection. It is shared later by a multi-channel receiver.

Test Plan:
- Loopback, normal word: AR_TXD with Nvel=2, ADR=8'h8D, DAT=23'h702D00, st pulsed. Required response:
  - ar_rxd with Nvel=2: rdy pulses once;
  - ADR=8'h8D, DAT=23'h702D00, par_ok=1 (11 ones in label+data, so parity bit 0);
  - en_rx high for the whole word.
- Parity fault: drive the same word directly with the parity bit flipped to 1 -> rdy=1, par_ok=0, ADR/DAT as sent.
- Glitch and timeout:
  - inject a 20-clock RXD1 pulse (below 500/8=62) between bits 5 and 6 -> ignored, word still correct;
  - then stop the line after 10 bits -> err_frm pulses ~1000 clocks after bit 10; ADR/DAT keep their previous values.
- Line fault: assert RXD0 and RXD1 together for 100 clocks mid-word -> err_line pulses once, no rdy, no err_frm. The next clean word is received correctly.
- Rates and back-to-back: for Nvel=0,1,3, send two consecutive words with a 4-bit gap (second: ADR=8'h01, DAT=23'h7FFFFF) -> two rdy pulses with the correct values each.
- Reset: assert rst at bit 20 -> all outputs 0 immediately. A full word after release is received correctly.
